// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage; MEM wins, bounded IF starvation.
// Optional conflict counter enabled by defining ARB_PERF_CNT_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 6,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              ex_rd,
  input  logic              ex_wr,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_wdata,
  output logic [31:0]       ex_rdata,
  output logic              ex_done,
  output logic              stall_ex,
  output logic              err_rdwr,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [2:0]        m_funct3,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {PRIO_EX, FORCE_IF} state_t;

  localparam logic [3:0] LP_SAT = 4'(MAX_STARVE - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [31:0] r_if_rdata;
  logic [31:0] r_ex_rdata;
  logic        r_if_valid;
  logic        r_ex_done;
  logic        r_err_rdwr;
  logic        w_ex_pend;
  logic        w_conflict;
  logic        w_grant_if;
  logic        w_grant_ex;

  assign w_ex_pend  = ex_rd | ex_wr;
  assign w_conflict = if_req & w_ex_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= PRIO_EX;
    else      r_state <= w_state_nxt;
  end

  // A conflict seen in PRIO_EX is always won by EX, so conflict alone qualifies the grant.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      PRIO_EX:  if (w_conflict && (r_starve_cnt == LP_SAT)) w_state_nxt = FORCE_IF;
      FORCE_IF: w_state_nxt = PRIO_EX;
      default:  w_state_nxt = PRIO_EX;
    endcase
  end

  // Grants are suppressed while reset is held so the memory sees no access.
  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ex = 1'b0;
    m_read     = 1'b0;
    m_write    = 1'b0;
    m_addr     = '0;
    m_funct3   = '0;
    m_wdata    = '0;
    if (rst) begin
      unique case (r_state)
        FORCE_IF: begin
          w_grant_if = if_req;
          w_grant_ex = w_ex_pend & ~if_req;
        end
        default: begin
          w_grant_ex = w_ex_pend;
          w_grant_if = if_req & ~w_ex_pend;
        end
      endcase
    end
    if (w_grant_ex) begin
      m_read   = ex_rd & ~ex_wr;
      m_write  = ex_wr;
      m_addr   = ex_addr;
      m_funct3 = ex_funct3;
      m_wdata  = ex_wdata;
    end else if (w_grant_if) begin
      m_read   = 1'b1;
      m_addr   = if_addr;
      m_funct3 = 3'b010;
    end
  end

  assign stall_if = if_req & ~w_grant_if & rst;
  assign stall_ex = w_ex_pend & ~w_grant_ex & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                r_starve_cnt <= '0;
    else if (w_grant_if || !if_req)          r_starve_cnt <= '0;
    else if (w_conflict && w_grant_ex && (r_starve_cnt != LP_SAT))
                                             r_starve_cnt <= r_starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rdata <= '0;
      r_ex_rdata <= '0;
      r_if_valid <= 1'b0;
      r_ex_done  <= 1'b0;
      r_err_rdwr <= 1'b0;
    end else begin
      r_if_valid <= w_grant_if;
      r_ex_done  <= w_grant_ex;
      if (w_grant_if)                      r_if_rdata <= m_rdata;
      if (w_grant_ex && ex_rd && !ex_wr)   r_ex_rdata <= m_rdata;
      if (ex_rd && ex_wr)                  r_err_rdwr <= 1'b1;
    end
  end

  assign if_rdata = r_if_rdata;
  assign ex_rdata = r_ex_rdata;
  assign if_valid = r_if_valid;
  assign ex_done  = r_ex_done;
  assign err_rdwr = r_err_rdwr;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     r_conflict_cnt <= '0;
    else if (w_conflict && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end

  assign conflict_cnt = r_conflict_cnt;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_unified_mem_arbiter;

  localparam int MAX_STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [5:0]  if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        stall_if;
  logic        ex_rd;
  logic        ex_wr;
  logic [5:0]  ex_addr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_wdata;
  logic [31:0] ex_rdata;
  logic        ex_done;
  logic        stall_ex;
  logic        err_rdwr;
  logic        m_read;
  logic        m_write;
  logic [5:0]  m_addr;
  logic [2:0]  m_funct3;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic [15:0] conflict_cnt;

  unified_mem_arbiter #(.ADDR_W(6), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .stall_if(stall_if),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_addr(ex_addr), .ex_funct3(ex_funct3), .ex_wdata(ex_wdata),
    .ex_rdata(ex_rdata), .ex_done(ex_done), .stall_ex(stall_ex), .err_rdwr(err_rdwr),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_funct3(m_funct3), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int unsigned a);
    if (a == 3) return 32'h00500093;
    return 32'h1357_9BDF ^ (a * 32'h9E37_79B1);
  endfunction

  // Environment memory attached to the DUT: combinational read, posedge write.
  logic [31:0] envmem [64];
  initial begin
    for (int i = 0; i < 64; i++) envmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (m_write) envmem[m_addr] <= m_wdata;
    end
  end
  assign m_rdata = envmem[m_addr];

  // Reference model state
  logic [31:0] refmem [64];
  logic [31:0] exp_ifr, exp_exr;
  logic        exp_err;
  logic        force_if;
  int          denied;
  int          n_conf;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_ifr = '0; exp_exr = '0; exp_err = 1'b0;
    force_if = 1'b0; denied = 0; n_conf = 0;
  endtask

  // One cycle: entered at posedge+1, returns at next posedge+1.
  task automatic cyc(input logic ir, input logic [5:0] ia, input logic rd, input logic wr,
                     input logic [5:0] ea, input logic [2:0] f3, input logic [31:0] wd);
    logic pend, conf, gi, ge;
    if_req = ir; if_addr = ia; ex_rd = rd; ex_wr = wr;
    ex_addr = ea; ex_funct3 = f3; ex_wdata = wd;
    #3;
    pend = rd | wr;
    conf = ir & pend;
    if (force_if) begin gi = ir;         ge = pend & ~ir; end
    else          begin gi = ir & ~pend; ge = pend;       end
    chk("m_read",   {31'd0, m_read},   {31'd0, gi | (ge & rd & ~wr)});
    chk("m_write",  {31'd0, m_write},  {31'd0, ge & wr});
    chk("stall_if", {31'd0, stall_if}, {31'd0, ir & ~gi});
    chk("stall_ex", {31'd0, stall_ex}, {31'd0, pend & ~ge});
    chk("m_addr",   {26'd0, m_addr},   {26'd0, gi ? ia : (ge ? ea : 6'd0)});
    chk("m_wdata",  m_wdata,           ge ? wd : 32'd0);
    if (gi)      chk("m_funct3", {29'd0, m_funct3}, 32'd2);
    else if (ge) chk("m_funct3", {29'd0, m_funct3}, {29'd0, f3});
    if (gi) exp_ifr = refmem[ia];
    if (ge && rd && !wr) exp_exr = refmem[ea];
    if (ge && wr) refmem[ea] = wd;
    if (rd && wr) exp_err = 1'b1;
    if (conf) n_conf++;
    // IF is forced through once it has lost MAX_STARVE consecutive conflicts.
    if (gi || !ir)        denied = 0;
    else if (conf && ge)  denied++;
    force_if = (denied == MAX_STARVE);
    @(posedge clk); #1;
    chk("if_valid", {31'd0, if_valid}, {31'd0, gi});
    chk("ex_done",  {31'd0, ex_done},  {31'd0, ge});
    chk("if_rdata", if_rdata, exp_ifr);
    chk("ex_rdata", ex_rdata, exp_exr);
    chk("err_rdwr", {31'd0, err_rdwr}, {31'd0, exp_err});
  endtask

  task automatic idle();
    cyc(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) refmem[i] = init_word(i);
    model_reset();
    rst = 1'b0;
    if_req = 0; if_addr = 0; ex_rd = 0; ex_wr = 0; ex_addr = 0; ex_funct3 = 0; ex_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_ex_done",  {31'd0, ex_done},  32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ex_rdata", ex_rdata, 32'd0);
    chk("rst_err",      {31'd0, err_rdwr}, 32'd0);
    chk("rst_m_read",   {31'd0, m_read},   32'd0);
    rst = 1'b1;

    // IF-only fetch of word 3
    cyc(1'b1, 6'h03, 1'b0, 1'b0, 6'd0, 3'd0, 32'd0);
    chk("fetch_word3", if_rdata, 32'h00500093);
    idle();

    // Store then load same address
    cyc(1'b0, 6'd0, 1'b0, 1'b1, 6'h0A, 3'b010, 32'hDEADBEEF);
    cyc(1'b0, 6'd0, 1'b1, 1'b0, 6'h0A, 3'b010, 32'd0);
    chk("load_after_store", ex_rdata, 32'hDEADBEEF);
    idle();

    // Six-cycle conflict: EX x4, IF, EX
    for (int i = 0; i < 6; i++) cyc(1'b1, 6'h05, 1'b1, 1'b0, 6'h0A, 3'b010, 32'd0);
    idle();

    // Simultaneous read+write treated as a store, sticky error
    cyc(1'b0, 6'd0, 1'b1, 1'b1, 6'h01, 3'b010, 32'h1);
    chk("rdwr_err_set", {31'd0, err_rdwr}, 32'd1);
    idle();
    idle();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic ir, rd, wr;
      int unsigned r;
      r  = $urandom_range(0, 15);
      ir = $urandom_range(0, 1) == 1;
      rd = (r < 6);
      wr = (r >= 5 && r < 11);
      cyc(ir, 6'($urandom_range(0, 63)), rd, wr, 6'($urandom_range(0, 63)),
          3'($urandom_range(0, 7)), $urandom);
    end

    // Drive into FORCE_IF, then reset in the middle of the conflict
    idle();
    for (int i = 0; i < MAX_STARVE; i++) cyc(1'b1, 6'h07, 1'b1, 1'b0, 6'h0B, 3'b010, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_async_m_read",   {31'd0, m_read},   32'd0);
    chk("rst_async_m_write",  {31'd0, m_write},  32'd0);
    chk("rst_async_stall_if", {31'd0, stall_if}, 32'd0);
    chk("rst_async_stall_ex", {31'd0, stall_ex}, 32'd0);
    chk("rst_async_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_async_ex_done",  {31'd0, ex_done},  32'd0);
    @(posedge clk); #1;
    chk("rst_err_clear", {31'd0, err_rdwr}, 32'd0);
    rst = 1'b1;
    model_reset();

    // Ten conflicts after reset; the first must go to EX
    for (int i = 0; i < 10; i++) cyc(1'b1, 6'h07, 1'b1, 1'b0, 6'h0B, 3'b010, 32'd0);
`ifdef ARB_PERF_CNT_EN
    chk("conflict_cnt", {16'd0, conflict_cnt}, n_conf);
`else
    chk("conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
